// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Access sizes, FSM states and the registered request bundle.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } lsu_state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        sgn;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic [2:0] nbytes_of(size_e size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic crosses_word(
        logic [1:0] off,
        size_e      size
    );
        return ({1'b0, off} + nbytes_of(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and DataMemory port of the LSU.
// slave = the LSU itself; master = core plus memory side.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid,
        output resp_rdata, resp_err,
        output mem_address, mem_write_data,
        output mem_write_enable, mem_read_enable
    );

    modport master (
        output req_valid, req_write, req_size,
        output req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err,
        input  mem_address, mem_write_data,
        input  mem_write_enable, mem_read_enable
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering between a two-word window and the core.
// Extracts load data and merges store data into old words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] new_lo,
    output logic [31:0] new_hi
);

    logic [31:0] win;
    logic [3:0]  bsel;
    logic [7:0]  bmask;
    logic [63:0] mask;
    logic [63:0] wide;

    always_comb begin
        win   = 32'({hi, lo} >> {off, 3'b000});
        rdata = win;
        unique case (1'b1)
            size == SZ_BYTE:
                rdata = {{24{sgn & win[7]}}, win[7:0]};
            size == SZ_HALF:
                rdata = {{16{sgn & win[15]}}, win[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        bsel = 4'b1111;
        unique case (1'b1)
            size == SZ_BYTE: bsel = 4'b0001;
            size == SZ_HALF: bsel = 4'b0011;
            default: ;
        endcase
        bmask = {4'b0000, bsel} << off;
        mask  = '0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{bmask[i]}};
        end
        wide = {32'b0, wdata} << {off, 3'b000};
        {new_hi, new_lo} = ({hi, lo} & ~mask) | (wide & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word requests into whole-word DataMemory cycles,
// using read-modify-write for sub-word stores and split accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1,
    parameter int ADDR_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       lo_word_q, lo_word_d;
    logic [31:0]       hi_word_q, hi_word_d;

    logic [1:0]        off;
    logic              span;
    logic              req_err;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    size_e             in_size;
    logic [1:0]        in_off;
    logic              in_err;
    logic              in_word_st;

    logic [31:0]       ext_rdata;
    logic [31:0]       new_lo;
    logic [31:0]       new_hi;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    assign off     = addr_q[1:0];
    assign span    = crosses_word(off, req_q.size);
    assign req_err = (req_q.size == SZ_RSVD)
                   || (span && !MISALIGN_EN);
    assign lo_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign hi_addr = lo_addr + ADDR_W'(4);

    assign in_size = size_e'(bus.req_size);
    assign in_off  = bus.req_addr[1:0];
    assign in_err  = (in_size == SZ_RSVD)
                   || (crosses_word(in_off, in_size)
                       && !MISALIGN_EN);
    assign in_word_st = bus.req_write
                      && (in_size == SZ_WORD)
                      && (in_off == 2'b00);

    lsu_align u_align (
        .lo     (lo_word_q),
        .hi     (hi_word_q),
        .off    (off),
        .size   (req_q.size),
        .sgn    (req_q.sgn),
        .wdata  (req_q.wdata),
        .rdata  (ext_rdata),
        .new_lo (new_lo),
        .new_hi (new_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            addr_q    <= '0;
            lo_word_q <= '0;
            hi_word_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            lo_word_q <= lo_word_d;
            hi_word_q <= hi_word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        lo_word_d = lo_word_q;
        hi_word_d = hi_word_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.write = bus.req_write;
                    req_d.size  = in_size;
                    req_d.sgn   = bus.req_signed;
                    req_d.wdata = bus.req_wdata;
                    addr_d      = bus.req_addr;
                    lo_word_d   = '0;
                    hi_word_d   = '0;
                    if (in_err) begin
                        state_d = ST_DONE;
                    end else if (in_word_st) begin
                        state_d = ST_WR_LO;
                    end else begin
                        state_d = ST_RD_LO;
                    end
                end
            end
            ST_RD_LO: begin
                mem_re    = 1'b1;
                mem_addr  = lo_addr;
                lo_word_d = bus.mem_read_data;
                if (span) begin
                    state_d = ST_RD_HI;
                end else if (req_q.write) begin
                    state_d = ST_WR_LO;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RD_HI: begin
                mem_re    = 1'b1;
                mem_addr  = hi_addr;
                hi_word_d = bus.mem_read_data;
                state_d   = req_q.write ? ST_WR_LO
                                        : ST_DONE;
            end
            ST_WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = lo_addr;
                mem_wdata = new_lo;
                state_d   = span ? ST_WR_HI : ST_DONE;
            end
            ST_WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = hi_addr;
                mem_wdata = new_hi;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = req_err;
                if (!req_err && !req_q.write) begin
                    rsp_rdata = ext_rdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset kills a pending memory cycle or response immediately.
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            rsp_err   = 1'b0;
        end
    end

    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.resp_valid       = rsp_valid;
    assign bus.resp_rdata       = rsp_rdata;
    assign bus.resp_err         = rsp_err;
    assign bus.mem_address      = mem_addr;
    assign bus.mem_write_data   = mem_wdata;
    assign bus.mem_write_enable = mem_we;
    assign bus.mem_read_enable  = mem_re;

endmodule
